// File: rtl/rv32_w_fp_writeback_arbiter_if.sv
// FP register-file write-port bundle: pipeline writeback, multi-cycle
// result handshake, write port and scoreboard outputs.
interface rv32_w_fp_writeback_arbiter_if #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
);
    logic                     wb_valid_i;
    logic [4:0]               wb_rd_i;
    logic [XLEN-1:0]          wb_data_i;
    logic                     mc_issue_i;
    logic [4:0]               mc_issue_rd_i;
    logic                     mc_valid_i;
    logic [4:0]               mc_rd_i;
    logic [XLEN-1:0]          mc_data_i;
    logic                     mc_ready_o;
    logic                     fp_we_o;
    logic [4:0]               fp_waddr_o;
    logic [XLEN-1:0]          fp_wdata_o;
    logic [31:0]              busy_o;
    logic [$clog2(DEPTH):0]   fifo_count_o;

    modport master (
        output wb_valid_i, wb_rd_i, wb_data_i,
        output mc_issue_i, mc_issue_rd_i,
        output mc_valid_i, mc_rd_i, mc_data_i,
        input  mc_ready_o, fp_we_o, fp_waddr_o, fp_wdata_o,
        input  busy_o, fifo_count_o
    );

    modport slave (
        input  wb_valid_i, wb_rd_i, wb_data_i,
        input  mc_issue_i, mc_issue_rd_i,
        input  mc_valid_i, mc_rd_i, mc_data_i,
        output mc_ready_o, fp_we_o, fp_waddr_o, fp_wdata_o,
        output busy_o, fifo_count_o
    );
endinterface

// File: rtl/rv32_w_fp_writeback_arbiter.sv
// FP register-file write-port arbiter: in-order pipeline writebacks win,
// buffered multi-cycle results drain in idle slots; busy scoreboard out.
module rv32_w_fp_writeback_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    rv32_w_fp_writeback_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     busy_q;
    logic [31:0]     busy_nxt;

    logic empty;
    logic ready;
    logic push;
    logic pop;
    logic [4:0] head_rd;

    assign empty   = (count_q == '0);
    assign ready   = (count_q < CW'(DEPTH));
    assign push    = bus.mc_valid_i && ready;
    assign pop     = !bus.wb_valid_i && !empty;
    assign head_rd = rd_mem[rd_ptr_q];

    assign bus.mc_ready_o   = ready;
    assign bus.busy_o       = busy_q;
    assign bus.fifo_count_o = count_q;

    // Combinational so the negedge-sampling register file sees it this cycle
    always_comb begin
        bus.fp_we_o    = 1'b0;
        bus.fp_waddr_o = '0;
        bus.fp_wdata_o = '0;
        if (!rst_i) begin
            if (bus.wb_valid_i) begin
                bus.fp_we_o    = 1'b1;
                bus.fp_waddr_o = bus.wb_rd_i;
                bus.fp_wdata_o = bus.wb_data_i;
            end else if (!empty) begin
                bus.fp_we_o    = 1'b1;
                bus.fp_waddr_o = head_rd;
                bus.fp_wdata_o = data_mem[rd_ptr_q];
            end
        end
    end

    // Clear first so a same-cycle issue to the popped rd keeps it busy
    always_comb begin
        busy_nxt = busy_q;
        if (pop) begin
            busy_nxt[head_rd] = 1'b0;
        end
        if (bus.mc_issue_i) begin
            busy_nxt[bus.mc_issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            busy_q <= busy_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= bus.mc_rd_i;
            data_mem[wr_ptr_q] <= bus.mc_data_i;
        end
    end

    a_wb_not_busy : assert property (
        @(posedge clk_i) disable iff (rst_i)
        bus.wb_valid_i |-> !busy_q[bus.wb_rd_i]
    );
endmodule
